// File: rtl/hs_pkg.sv
// Shared types and helpers for the hs packet receiver.
// Holds the FSM state type and the FIFO pointer-width helper.
package hs_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      DRAIN = 2'd2
   } hs_state_t;

   // One extra bit beyond the address so full and empty can be told apart
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/hs_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers for the packet receiver.
// Head data reads as zero while empty.
module hs_sync_fifo
   import hs_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ONE;
         if (do_pop)  rd_ptr <= rd_ptr + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/hs_pkt_receiver.sv
// Valid/ready packet receiver: FIFO-buffered beats, length count, done pulse.
// Optional even-parity check on each beat when HS_RX_PARITY_EN is defined.
module hs_pkt_receiver
   import hs_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
`ifdef HS_RX_PARITY_EN
   input  logic              in_parity,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              pkt_done,
   output logic [LEN_W-1:0]  pkt_len,
   output logic              len_ovf,
   output logic              par_err
);

   localparam int FW = DATA_W + 1;
   localparam logic [LEN_W-1:0] LEN_MAX = '1;

   hs_state_t state_q;
   hs_state_t state_d;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          start;
   logic [FW-1:0] head;

   // in_ready depends only on registered state, never on out_ready
   assign in_ready  = (state_q == RECV) && !full;
   assign push      = in_valid && in_ready;
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign {out_last, out_data} = head;

   hs_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data ({in_last, in_data}),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      pkt_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = RECV;
               start   = 1'b1;
            end
         end
         RECV: begin
            if (push && in_last) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && out_last) begin
               state_d  = IDLE;
               pkt_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_len <= '0;
         len_ovf <= 1'b0;
      end else if (start) begin
         pkt_len <= '0;
         len_ovf <= 1'b0;
      end else if (push) begin
         if (pkt_len == LEN_MAX) len_ovf <= 1'b1;
         else                    pkt_len <= pkt_len + 1'b1;
      end
   end

`ifdef HS_RX_PARITY_EN
   logic par_bad;

   assign par_bad = push && (^{in_data, in_parity});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         par_err <= 1'b0;
      else if (start)   par_err <= 1'b0;
      else if (par_bad) par_err <= 1'b1;
   end
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_pkt_receiver.sv
// Randomised bench for hs_pkt_receiver against a queue-based packet model.
// Parity scenario adapts to whether HS_RX_PARITY_EN is defined.
module tb_hs_pkt_receiver;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int LW    = 8;
`ifdef HS_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0] d;
      bit            l;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
`ifdef HS_RX_PARITY_EN
   logic          in_parity = 1'b0;
`endif
   logic          out_ready = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          pkt_done;
   logic [LW-1:0] pkt_len;
   logic          len_ovf;
   logic          par_err;

   int vectors = 0;
   int miscompares = 0;

   // Model: FIFO contents as a queue plus packet phase 0 idle/1 recv/2 drain
   beat_t         mq[$];
   int            mst = 0;
   logic [LW-1:0] mlen = '0;
   bit            movf = 1'b0;
   bit            mpar = 1'b0;
   bit            dacc;

   logic [DW-1:0] pkt[$];
   bit            ppar[$];

   always #5 clk = ~clk;

   hs_pkt_receiver #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .LEN_W  (LW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
`ifdef HS_RX_PARITY_EN
      .in_parity (in_parity),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .pkt_done  (pkt_done),
      .pkt_len   (pkt_len),
      .len_ovf   (len_ovf),
      .par_err   (par_err)
   );

   task automatic model_clear();
      mq.delete();
      mst  = 0;
      mlen = '0;
      movf = 1'b0;
      mpar = 1'b0;
   endtask

   task automatic fill(input int n);
      pkt.delete();
      ppar.delete();
      for (int i = 0; i < n; i++) begin
         pkt.push_back(DW'($urandom));
         ppar.push_back(^pkt[i]);
      end
   endtask

   // One clock: drive, sample mid-cycle, compare with model, advance model
   task automatic step(input bit iv, input logic [DW-1:0] d, input bit l,
                       input bit p, input bit ordy, input bit en);
      bit    eir;
      bit    eov;
      bit    pop;
      bit    push;
      bit    edone;
      beat_t hd;
      in_valid  = iv;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
      enable    = en;
`ifdef HS_RX_PARITY_EN
      in_parity = p;
`endif
      #2;
      hd    = '{d: '0, l: 1'b0};
      eir   = (mst == 1) && (mq.size() < DEPTH);
      eov   = (mq.size() != 0);
      if (eov) hd = mq[0];
      pop   = eov && ordy;
      edone = pop && (mst == 2) && hd.l;
      push  = iv && eir;
      dacc  = iv && in_ready;
      vectors++;
      if (in_ready !== eir) begin
         miscompares++;
         $display("FAIL in_ready got=%b exp=%b t=%0t", in_ready, eir, $time);
      end
      vectors++;
      if (out_valid !== eov) begin
         miscompares++;
         $display("FAIL out_valid got=%b exp=%b t=%0t", out_valid, eov, $time);
      end
      if (eov) begin
         vectors++;
         if ({out_last, out_data} !== {hd.l, hd.d}) begin
            miscompares++;
            $display("FAIL head got=%b/%h exp=%b/%h t=%0t",
                     out_last, out_data, hd.l, hd.d, $time);
         end
      end
      vectors++;
      if (pkt_done !== edone) begin
         miscompares++;
         $display("FAIL pkt_done got=%b exp=%b t=%0t", pkt_done, edone, $time);
      end
      vectors++;
      if ({len_ovf, pkt_len} !== {movf, mlen}) begin
         miscompares++;
         $display("FAIL len got=%b/%0d exp=%b/%0d t=%0t",
                  len_ovf, pkt_len, movf, mlen, $time);
      end
      vectors++;
      if (par_err !== mpar) begin
         miscompares++;
         $display("FAIL par_err got=%b exp=%b t=%0t", par_err, mpar, $time);
      end
      if (pop) void'(mq.pop_front());
      case (mst)
         0: if (en) begin
               mst  = 1;
               mlen = '0;
               movf = 1'b0;
               mpar = 1'b0;
            end
         1: if (push) begin
               mq.push_back('{d: d, l: l});
               if (mlen == '1) movf = 1'b1;
               else            mlen = mlen + 1'b1;
               if (PAR_EN && (^{d, p})) mpar = 1'b1;
               if (l) mst = 2;
            end
         default: if (edone) mst = 0;
      endcase
      @(posedge clk);
      #1;
   endtask

   // mode 0: out_ready=1; 1: random ready/valid; 2: ready after hold cycles
   task automatic run_pkt(input int mode, input int hold, input int first);
      int n;
      int sent;
      int cyc;
      bit ordy;
      bit iv;
      n    = pkt.size();
      sent = first;
      cyc  = 0;
      if (first == 0) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      while (!(sent == n && mst == 0) && cyc < 3000) begin
         case (mode)
            0:       ordy = 1'b1;
            1:       ordy = 1'($urandom_range(0, 1));
            default: ordy = (cyc >= hold);
         endcase
         iv = (sent < n) && (mode != 1 || $urandom_range(0, 3) != 0);
         if (sent < n)
            step(iv, pkt[sent], sent == n - 1, ppar[sent], ordy,
                 1'($urandom_range(0, 1)));
         else
            step(1'b0, '0, 1'b0, 1'b0, ordy, 1'($urandom_range(0, 1)));
         if (dacc) sent++;
         cyc++;
      end
      vectors++;
      if (!(sent == n && mst == 0)) begin
         miscompares++;
         $display("FAIL pkt_timeout sent=%0d exp=%0d", sent, n);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL leftover out_valid got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      vectors++;
      if ({in_ready, out_valid, out_data, out_last, pkt_done, pkt_len, len_ovf, par_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got=%b/%b/%h/%b/%b/%0d/%b/%b exp=all0",
                  in_ready, out_valid, out_data, out_last, pkt_done,
                  pkt_len, len_ovf, par_err);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      pkt.delete();
      ppar.delete();
      pkt.push_back(8'h11);
      pkt.push_back(8'h22);
      pkt.push_back(8'h33);
      foreach (pkt[i]) ppar.push_back(^pkt[i]);
      run_pkt(0, 0, 0);
      vectors++;
      if ({len_ovf, pkt_len} !== {1'b0, 8'd3}) begin
         miscompares++;
         $display("FAIL single_len got=%b/%0d exp=0/3", len_ovf, pkt_len);
      end
   endtask

   task automatic test_backpressure();
      int cnt;
      fill(6);
      cnt = 0;
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, pkt[cnt], cnt == 5, ppar[cnt], 1'b0, 1'b0);
         if (dacc) cnt++;
      end
      vectors++;
      if (cnt !== DEPTH) begin
         miscompares++;
         $display("FAIL bp_accepted got=%0d exp=%0d", cnt, DEPTH);
      end
      step(1'b1, pkt[cnt], cnt == 5, ppar[cnt], 1'b1, 1'b0);
      vectors++;
      if (dacc !== 1'b0) begin
         miscompares++;
         $display("FAIL full_pop_push got=%b exp=0", dacc);
      end
      if (dacc) cnt++;
      step(1'b1, pkt[cnt], cnt == 5, ppar[cnt], 1'b1, 1'b0);
      vectors++;
      if (dacc !== 1'b1) begin
         miscompares++;
         $display("FAIL push_after_pop got=%b exp=1", dacc);
      end
      if (dacc) cnt++;
      run_pkt(0, 0, cnt);
      vectors++;
      if (pkt_len !== 8'd6) begin
         miscompares++;
         $display("FAIL bp_len got=%0d exp=6", pkt_len);
      end
   endtask

   task automatic test_random();
      int n;
      for (int k = 0; k < 6; k++) begin
         n = $urandom_range(1, 12);
         fill(n);
         run_pkt(1, 0, 0);
         vectors++;
         if (pkt_len !== LW'(n)) begin
            miscompares++;
            $display("FAIL rand_len got=%0d exp=%0d", pkt_len, n);
         end
      end
   endtask

   task automatic test_saturation();
      fill(258);
      run_pkt(0, 0, 0);
      vectors++;
      if ({len_ovf, pkt_len} !== {1'b1, 8'd255}) begin
         miscompares++;
         $display("FAIL sat got=%b/%0d exp=1/255", len_ovf, pkt_len);
      end
      fill(2);
      run_pkt(2, 3, 0);
      vectors++;
      if ({len_ovf, pkt_len} !== {1'b0, 8'd2}) begin
         miscompares++;
         $display("FAIL sat_clear got=%b/%0d exp=0/2", len_ovf, pkt_len);
      end
   endtask

   task automatic test_parity();
      fill(3);
      pkt[0]  = 8'h01;
      ppar[0] = 1'b0;
      run_pkt(0, 0, 0);
      vectors++;
      if (par_err !== PAR_EN) begin
         miscompares++;
         $display("FAIL par_bad got=%b exp=%b", par_err, PAR_EN);
      end
      fill(4);
      run_pkt(1, 0, 0);
      vectors++;
      if (par_err !== 1'b0) begin
         miscompares++;
         $display("FAIL par_good got=%b exp=0", par_err);
      end
   endtask

   task automatic test_reset_mid();
      fill(4);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, pkt[0], 1'b0, ppar[0], 1'b0, 1'b0);
      step(1'b1, pkt[1], 1'b0, ppar[1], 1'b0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      vectors++;
      if ({out_valid, in_ready, pkt_len, pkt_done} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset got=%b/%b/%0d/%b exp=0/0/0/0",
                  out_valid, in_ready, pkt_len, pkt_done);
      end
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      fill(2);
      run_pkt(0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_random();
      test_saturation();
      test_parity();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
